// File: rtl/pe_ctx_pkg.sv
// Package for the per-PE context sequencer.
// Holds the context word layout, the NOP control word and the FSM state encoding.
package pe_ctx_pkg;

    localparam int CTX_W        = 64;

    localparam int IN_LSB       = 0;
    localparam int IN_W         = 9;
    localparam int OUT_LSB      = 9;
    localparam int OUT_W        = 9;
    localparam int REG1_LSB     = 18;
    localparam int REG2_LSB     = 24;
    localparam int PUT_IN_LSB   = 30;
    localparam int PUT_OUT_LSB  = 36;
    localparam int SEND_LSB     = 42;
    localparam int REG_W        = 6;
    localparam int PE2FU1_LSB   = 48;
    localparam int PE2FU2_LSB   = 52;
    localparam int PE2FU_W      = 4;
    localparam int WB_EN_BIT    = 56;
    localparam int LD_BIT       = 57;
    localparam int LD_WRITE_BIT = 58;
    localparam int LAST_BIT     = 59;
    localparam int PARITY_BIT   = 63;

    // Control bits actually driven toward the PE: everything below 'last'.
    localparam int CTRL_W       = 59;

    // NOP: no reg-file write (ld=1, ld_write=0), FU operands select constant 0.
    localparam logic [CTX_W-1:0]  NOP_WORD = 64'h0244_0000_0000_0000;
    localparam logic [CTRL_W-1:0] NOP_CTRL = NOP_WORD[CTRL_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pe_ctx_mem.sv
// Context store: DEPTH x CTX_W flop array.
// Synchronous write, combinational read, intentionally no reset so the
// program survives a sequencer reset.
// Ports: CLK; we/waddr/wdata write port; raddr/rdata asynchronous read port.
module pe_ctx_mem
    import pe_ctx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CTX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [CTX_W-1:0] rdata
);

    logic [CTX_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctx_seq.sv
// Per-PE context sequencer: stores CTX_DEPTH context words and replays them,
// one per cycle, onto registered PE control outputs for iter_count passes.
// Optional feature macro: PE_CTX_PARITY_EN (even parity in bit 63, adds par_err).
// Ports: CLK/RST (async, active-high); cfg_we/cfg_addr/cfg_wdata config write;
//        start/iter_count/stall sequencing; busy/done/cfg_err status; ctx_pc;
//        control_* / wb_en / ld / ld_write PE controls; par_err (parity build).
//
//  state | meaning
//  IDLE  | controls NOP, config writes accepted, waits for start
//  RUN   | issues mem[pc] each non-stalled cycle
//  DONE  | one-cycle done pulse, then back to IDLE
module pe_ctx_seq
    import pe_ctx_pkg::*;
#(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_AW    = 4,
    parameter int ITER_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_we,
    input  logic [CTX_AW-1:0] cfg_addr,
    input  logic [CTX_W-1:0]  cfg_wdata,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_count,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [CTX_AW-1:0] ctx_pc,
    output logic [8:0]        control_in,
    output logic [8:0]        control_out,
    output logic [5:0]        control_reg_1,
    output logic [5:0]        control_reg_2,
    output logic [5:0]        control_put_in,
    output logic [5:0]        control_put_out,
    output logic [5:0]        control_send,
    output logic [3:0]        control_pe2fu_1,
    output logic [3:0]        control_pe2fu_2,
    output logic              wb_en,
    output logic              ld,
    output logic              ld_write
`ifdef PE_CTX_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam logic [CTX_AW-1:0] PC_MAX = CTX_AW'(CTX_DEPTH - 1);

    state_t              state_q, state_nx;
    logic [CTX_AW-1:0]   pc_q, pc_nx;
    logic [ITER_W-1:0]   iter_q, iter_nx;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_nx;
    logic [CTX_AW-1:0]   ctx_pc_q, ctx_pc_nx;
    logic                busy_q, busy_nx;
    logic                done_q, done_nx;
    logic                cfg_err_q, cfg_err_nx;
    logic                mem_we;
    logic [CTX_W-1:0]    rd_word;
    logic                end_of_pass;
    logic                par_bad;

    pe_ctx_mem #(
        .DEPTH (CTX_DEPTH),
        .AW    (CTX_AW)
    ) u_mem (
        .CLK   (CLK),
        .we    (mem_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (pc_q),
        .rdata (rd_word)
    );

`ifdef PE_CTX_PARITY_EN
    // Even parity across the whole word: any odd bit count means corruption.
    assign par_bad = ^rd_word;
`else
    logic unused_bits;
    assign par_bad     = 1'b0;
    assign unused_bits = ^rd_word[CTX_W-1:LAST_BIT+1];
`endif

    assign end_of_pass = rd_word[LAST_BIT] || (pc_q == PC_MAX);

    always_comb begin
        state_nx   = state_q;
        pc_nx      = pc_q;
        iter_nx    = iter_q;
        ctrl_nx    = NOP_CTRL;
        ctx_pc_nx  = ctx_pc_q;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        cfg_err_nx = cfg_we && (state_q != ST_IDLE);
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Write lands on this edge; a same-cycle start reads it next cycle.
                mem_we = cfg_we;
                if (start) begin
                    if (iter_count != '0) begin
                        iter_nx  = iter_count;
                        pc_nx    = '0;
                        state_nx = ST_RUN;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                busy_nx = 1'b1;
                if (!stall) begin
                    if (par_bad) begin
                        state_nx = ST_DONE;
                    end else begin
                        ctrl_nx   = rd_word[CTRL_W-1:0];
                        ctx_pc_nx = pc_q;
                        if (end_of_pass) begin
                            pc_nx   = '0;
                            iter_nx = iter_q - ITER_W'(1);
                            if (iter_q == ITER_W'(1)) begin
                                state_nx = ST_DONE;
                            end
                        end else begin
                            pc_nx = pc_q + CTX_AW'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            iter_q    <= '0;
            ctrl_q    <= NOP_CTRL;
            ctx_pc_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_nx;
            pc_q      <= pc_nx;
            iter_q    <= iter_nx;
            ctrl_q    <= ctrl_nx;
            ctx_pc_q  <= ctx_pc_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
            cfg_err_q <= cfg_err_nx;
        end
    end

`ifdef PE_CTX_PARITY_EN
    // Remember the parity abort so par_err coincides with the done pulse.
    logic par_hit_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_hit_q <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            if (state_q == ST_RUN && !stall && par_bad) begin
                par_hit_q <= 1'b1;
            end else if (state_q == ST_DONE) begin
                par_hit_q <= 1'b0;
            end
            par_err <= (state_q == ST_DONE) && par_hit_q;
        end
    end
`endif

    assign busy            = busy_q;
    assign done            = done_q;
    assign cfg_err         = cfg_err_q;
    assign ctx_pc          = ctx_pc_q;
    assign control_in      = ctrl_q[IN_LSB      +: IN_W];
    assign control_out     = ctrl_q[OUT_LSB     +: OUT_W];
    assign control_reg_1   = ctrl_q[REG1_LSB    +: REG_W];
    assign control_reg_2   = ctrl_q[REG2_LSB    +: REG_W];
    assign control_put_in  = ctrl_q[PUT_IN_LSB  +: REG_W];
    assign control_put_out = ctrl_q[PUT_OUT_LSB +: REG_W];
    assign control_send    = ctrl_q[SEND_LSB    +: REG_W];
    assign control_pe2fu_1 = ctrl_q[PE2FU1_LSB  +: PE2FU_W];
    assign control_pe2fu_2 = ctrl_q[PE2FU2_LSB  +: PE2FU_W];
    assign wb_en           = ctrl_q[WB_EN_BIT];
    assign ld              = ctrl_q[LD_BIT];
    assign ld_write        = ctrl_q[LD_WRITE_BIT];

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Testbench for pe_ctx_seq: table of program runs plus hand sequences for
// reset mid-run (and parity abort when PE_CTX_PARITY_EN is defined).
// Expected per-cycle outputs come from a small behavioural model pushed into
// a scoreboard queue and popped one entry per clock.
module tb_pe_ctx_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [63:0] cfg_wdata;
    logic        start;
    logic [15:0] iter_count;
    logic        stall;
    logic        busy, done, cfg_err;
    logic [3:0]  ctx_pc;
    logic [8:0]  control_in, control_out;
    logic [5:0]  control_reg_1, control_reg_2, control_put_in, control_put_out, control_send;
    logic [3:0]  control_pe2fu_1, control_pe2fu_2;
    logic        wb_en, ld, ld_write;
`ifdef PE_CTX_PARITY_EN
    logic        par_err;
`endif

    always #5 CLK = ~CLK;

    pe_ctx_seq dut (
        .CLK             (CLK),
        .RST             (RST),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .start           (start),
        .iter_count      (iter_count),
        .stall           (stall),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .ctx_pc          (ctx_pc),
        .control_in      (control_in),
        .control_out     (control_out),
        .control_reg_1   (control_reg_1),
        .control_reg_2   (control_reg_2),
        .control_put_in  (control_put_in),
        .control_put_out (control_put_out),
        .control_send    (control_send),
        .control_pe2fu_1 (control_pe2fu_1),
        .control_pe2fu_2 (control_pe2fu_2),
        .wb_en           (wb_en),
        .ld              (ld),
        .ld_write        (ld_write)
`ifdef PE_CTX_PARITY_EN
        ,
        .par_err         (par_err)
`endif
    );

    logic [58:0] ctrl_obs;
    assign ctrl_obs = {ld_write, ld, wb_en, control_pe2fu_2, control_pe2fu_1, control_send,
                       control_put_out, control_put_in, control_reg_2, control_reg_1,
                       control_out, control_in};

    typedef struct {
        logic [58:0] ctrl;
        logic        busy;
        logic        done;
        logic        cfg_err;
        logic        par;
        logic        chk_pc;
        logic [3:0]  pc;
    } exp_t;

    typedef struct {
        int load;       // 0 keep memory, 1 three-word program (word 2 last), 2 sixteen words no last
        int iter;
        int stall_at;   // contexts issued before the stall window
        int stall_len;
        int err_at;     // clock index (1-based after start) with cfg_we during RUN; 0 none
        bit wr0;        // rewrite word 0 in the start cycle
        int exp_busy;   // busy cycles for the whole run
    } vec_t;

    exp_t        sb_q[$];
    logic [63:0] model_mem [16];
    logic [58:0] nop;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          busy_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input logic last);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[62:60] = 3'b000;
        w[59]    = last;
        w[63]    = ^w[62:0];
        return w;
    endfunction

    task automatic tick(input bit chk);
        exp_t e;
        @(posedge CLK);
        #1;
        if (chk) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue expected entry");
            end else begin
                e = sb_q.pop_front();
                check("ctrl", {5'b0, ctrl_obs}, {5'b0, e.ctrl});
                check("busy", {63'b0, busy}, {63'b0, e.busy});
                check("done", {63'b0, done}, {63'b0, e.done});
                check("cfg_err", {63'b0, cfg_err}, {63'b0, e.cfg_err});
                if (e.chk_pc) check("ctx_pc", {60'b0, ctx_pc}, {60'b0, e.pc});
`ifdef PE_CTX_PARITY_EN
                check("par_err", {63'b0, par_err}, {63'b0, e.par});
`endif
            end
        end
    endtask

    task automatic cfg_write(input int addr, input logic [63:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr[3:0];
        cfg_wdata = data;
        model_mem[addr] = data;
        tick(0);
        cfg_we = 1'b0;
    endtask

    function automatic exp_t mk_exp(input logic [58:0] c, input logic b, input logic d,
                                    input logic chk, input int pc);
        exp_t e;
        e.ctrl = c; e.busy = b; e.done = d; e.cfg_err = 1'b0; e.par = 1'b0;
        e.chk_pc = chk; e.pc = pc[3:0];
        return e;
    endfunction

    // Reference model: walk the program pass by pass, inserting stall NOPs.
    task automatic push_run(input int iter, input int stall_at, input int stall_len, input int err_at);
        int   k = 0;
        int   base = sb_q.size();
        exp_t e;
        for (int it = 0; it < iter; it++) begin
            for (int pc = 0; pc < 16; pc++) begin
                if (k == stall_at)
                    for (int s = 0; s < stall_len; s++) sb_q.push_back(mk_exp(nop, 1'b1, 1'b0, 1'b0, 0));
                sb_q.push_back(mk_exp(model_mem[pc][58:0], 1'b1, 1'b0, 1'b1, pc));
                k++;
                if (model_mem[pc][59]) break;
            end
        end
        sb_q.push_back(mk_exp(nop, 1'b0, 1'b1, 1'b0, 0));
        sb_q.push_back(mk_exp(nop, 1'b0, 1'b0, 1'b0, 0));
        if (err_at > 0) begin
            e = sb_q[base + err_at - 1];
            e.cfg_err = 1'b1;
            sb_q[base + err_at - 1] = e;
        end
    endtask

    task automatic drive_run(input int iter, input int stall_at, input int stall_len,
                             input int err_at, input bit wr0);
        int n;
        if (wr0) begin
            cfg_we    = 1'b1;
            cfg_addr  = 4'd0;
            cfg_wdata = mk_word(1'b0);
            model_mem[0] = cfg_wdata;
        end
        push_run(iter, stall_at, stall_len, err_at);
        n = sb_q.size();
        start      = 1'b1;
        iter_count = iter[15:0];
        tick(0);
        start      = 1'b0;
        cfg_we     = 1'b0;
        iter_count = 16'($urandom);
        busy_cnt   = 0;
        for (int k = 1; k <= n; k++) begin
            stall = (k > stall_at) && (k <= stall_at + stall_len);
            if (k == err_at) begin
                cfg_we    = 1'b1;
                cfg_addr  = 4'd1;
                cfg_wdata = mk_word(1'b1);
            end
            tick(1);
            cfg_we = 1'b0;
            if (busy) busy_cnt++;
        end
        stall = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        nop = '0;
        nop[57] = 1'b1;
        nop[51:48] = 4'b0100;
        nop[55:52] = 4'b0100;

        vecs[0] = '{load: 1, iter: 3, stall_at: 0,  stall_len: 0, err_at: 0, wr0: 0, exp_busy: 9};
        vecs[1] = '{load: 0, iter: 3, stall_at: 1,  stall_len: 2, err_at: 0, wr0: 0, exp_busy: 11};
        vecs[2] = '{load: 0, iter: 0, stall_at: 0,  stall_len: 0, err_at: 0, wr0: 0, exp_busy: 0};
        vecs[3] = '{load: 0, iter: 1, stall_at: 0,  stall_len: 0, err_at: 2, wr0: 0, exp_busy: 3};
        vecs[4] = '{load: 0, iter: 1, stall_at: 0,  stall_len: 0, err_at: 0, wr0: 0, exp_busy: 3};
        vecs[5] = '{load: 0, iter: 2, stall_at: 0,  stall_len: 1, err_at: 0, wr0: 0, exp_busy: 7};
        vecs[6] = '{load: 0, iter: 1, stall_at: 0,  stall_len: 0, err_at: 0, wr0: 1, exp_busy: 3};
        vecs[7] = '{load: 2, iter: 2, stall_at: 0,  stall_len: 0, err_at: 0, wr0: 0, exp_busy: 32};
        vecs[8] = '{load: 0, iter: 1, stall_at: 15, stall_len: 3, err_at: 0, wr0: 0, exp_busy: 19};

        RST = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; iter_count = '0; stall = 1'b0;
        tick(0);
        tick(0);
        check("rst_ctrl", {5'b0, ctrl_obs}, {5'b0, nop});
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_cfg_err", {63'b0, cfg_err}, 64'd0);
        check("rst_ctx_pc", {60'b0, ctx_pc}, 64'd0);
        RST = 1'b0;
        tick(0);

        // Reset in the middle of a run, then replay from word 0.
        for (int i = 0; i < 4; i++) cfg_write(i, mk_word(i == 3));
        start = 1'b1; iter_count = 16'd1;
        tick(0);
        start = 1'b0;
        tick(0);
        tick(0);
        check("t1_mid_ctrl", {5'b0, ctrl_obs}, {5'b0, model_mem[1][58:0]});
        check("t1_mid_busy", {63'b0, busy}, 64'd1);
        RST = 1'b1;
        tick(0);
        check("t1_rst_ctrl", {5'b0, ctrl_obs}, {5'b0, nop});
        check("t1_rst_busy", {63'b0, busy}, 64'd0);
        check("t1_rst_pc", {60'b0, ctx_pc}, 64'd0);
        RST = 1'b0;
        tick(0);
        drive_run(1, 0, 0, 0, 1'b0);
        check("t1_busy_cycles", busy_cnt, 64'd4);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].load == 1) begin
                for (int i = 0; i < 3; i++) cfg_write(i, mk_word(i == 2));
            end else if (vecs[v].load == 2) begin
                for (int i = 0; i < 16; i++) cfg_write(i, mk_word(1'b0));
            end
            drive_run(vecs[v].iter, vecs[v].stall_at, vecs[v].stall_len, vecs[v].err_at, vecs[v].wr0);
            check($sformatf("vec%0d_busy_cycles", v), busy_cnt, vecs[v].exp_busy);
            check($sformatf("vec%0d_sb_drained", v), sb_q.size(), 64'd0);
        end

`ifdef PE_CTX_PARITY_EN
        begin
            logic [63:0] bad;
            exp_t        e;
            for (int i = 0; i < 3; i++) cfg_write(i, mk_word(i == 2));
            bad = model_mem[1];
            bad[5] = ~bad[5];
            cfg_write(1, bad);
            sb_q.push_back(mk_exp(model_mem[0][58:0], 1'b1, 1'b0, 1'b1, 0));
            sb_q.push_back(mk_exp(nop, 1'b1, 1'b0, 1'b0, 0));
            e = mk_exp(nop, 1'b0, 1'b1, 1'b0, 0);
            e.par = 1'b1;
            sb_q.push_back(e);
            sb_q.push_back(mk_exp(nop, 1'b0, 1'b0, 1'b0, 0));
            start = 1'b1; iter_count = 16'd2;
            tick(0);
            start = 1'b0;
            for (int k = 0; k < 4; k++) tick(1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
